dotp_wb_queue: RTL and testbench

// Writeback-side companion of the fixed-latency (PIPE_LAT) dot-product FU, which has no stall input.

---
 rtl/dotp_wb_queue.sv | 119 +++++++++++
 tb/tb_dotp_wb_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dotp_wb_queue.sv
// Result buffer between the fixed-latency dot-product FU and the writeback port; 0-cycle fall-through when empty, else head-of-queue.
// FU cannot stall, so issue credits (occupancy + inflight < DEPTH) keep the queue from ever being overrun by honest traffic.
module dotp_wb_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned PIPE_LAT      = 3,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic                         fu_valid_i,
  input  logic [XLEN-1:0]              fu_result_i,
  input  logic [TRANS_ID_BITS-1:0]     fu_trans_id_i,
  output logic                         wb_valid_o,
  output logic [XLEN-1:0]              wb_result_o,
  output logic [TRANS_ID_BITS-1:0]     wb_trans_id_o,
  input  logic                         wb_ready_i,
  output logic [$clog2(DEPTH):0]       occupancy_o,
  output logic                         overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PIPE_LAT < 1) begin : g_param_check
    $error("dotp_wb_queue: DEPTH must be a power of 2 >= 2 and PIPE_LAT >= 1");
  end

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } wb_entry_t;

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] occ_q, inflight_q, inflight_d;
  logic          overflow_q;

  logic          empty, full, fu_live, bypass, bypass_taken;
  logic          push, pop, wr_en, drop;
  logic [CW:0]   credit_sum;

  assign empty        = (occ_q == '0);
  assign full         = (occ_q == CW'(DEPTH));
  // rst_ni gates the fall-through so nothing leaks out while held in reset
  assign fu_live      = rst_ni & fu_valid_i & ~flush_i;
  assign bypass       = empty & fu_live;
  assign bypass_taken = bypass & wb_ready_i;
  assign push         = fu_live & ~bypass_taken;
  assign wb_valid_o   = ~flush_i & (~empty | fu_live);
  assign pop          = wb_valid_o & wb_ready_i & ~empty;
  assign wr_en        = push & (~full | pop);
  assign drop         = push & full & ~pop;

  assign credit_sum    = {1'b0, occ_q} + {1'b0, inflight_q};
  assign issue_ready_o = (credit_sum < (CW + 1)'(DEPTH));
  assign occupancy_o   = occ_q;
  assign overflow_o    = overflow_q;

  always_comb begin
    wb_result_o   = '0;
    wb_trans_id_o = '0;
    if (!empty) begin
      wb_result_o   = mem_q[rd_ptr_q].result;
      wb_trans_id_o = mem_q[rd_ptr_q].trans_id;
    end else if (bypass) begin
      wb_result_o   = fu_result_i;
      wb_trans_id_o = fu_trans_id_i;
    end
  end

  // inflight is clamped so a stray FU valid cannot wrap the credit count
  always_comb begin
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = '0;
    end else if (issue_valid_i && !fu_valid_i && inflight_q != CW'(DEPTH)) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue_valid_i && fu_valid_i && inflight_q != '0) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= '{result: fu_result_i, trans_id: fu_trans_id_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({wr_en, pop})
          2'b10:   occ_q <= occ_q + CW'(1);
          2'b01:   occ_q <= occ_q - CW'(1);
          default: occ_q <= occ_q;
        endcase
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dotp_wb_queue.sv
// Bench for dotp_wb_queue: FU pipeline model plus queue-level reference model, compared every cycle.
module tb_dotp_wb_queue;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  localparam int TIDW  = 4;
  localparam int XLEN  = 64;
  localparam int CW    = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni, flush_i, issue_valid_i, issue_ready_o;
  logic            fu_valid_i, wb_valid_o, wb_ready_i, overflow_o;
  logic [XLEN-1:0] fu_result_i, wb_result_o;
  logic [TIDW-1:0] fu_trans_id_i, wb_trans_id_o;
  logic [CW-1:0]   occupancy_o;

  dotp_wb_queue #(.DEPTH(DEPTH), .PIPE_LAT(LAT), .TRANS_ID_BITS(TIDW), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .fu_valid_i(fu_valid_i), .fu_result_i(fu_result_i), .fu_trans_id_i(fu_trans_id_i),
    .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_ready_i(wb_ready_i), .occupancy_o(occupancy_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {logic vld; logic [XLEN-1:0] res; logic [TIDW-1:0] id;} stage_t;
  typedef struct packed {logic [XLEN-1:0] res; logic [TIDW-1:0] id;} ent_t;

  ent_t            q[$];
  stage_t          pipe[LAT];
  bit              model_ov;
  logic [TIDW-1:0] wb_log[$];
  int              vectors = 0;
  int              miscompares = 0;
  bit              want, inj, fixed_en;
  ent_t            inj_ent;
  logic [XLEN-1:0] fixed_res, issue_res;
  logic [TIDW-1:0] next_id;
  int              issued;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int pipe_count();
    int n = 0;
    for (int i = 0; i < LAT; i++) if (pipe[i].vld) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    model_ov = 1'b0;
  endtask

  task automatic compare_model();
    bit   exp_v;
    ent_t e;
    if (!rst_ni) begin
      chk("rst wb_valid", 64'(wb_valid_o), 64'(0));
      chk("rst occupancy", 64'(occupancy_o), 64'(0));
      chk("rst issue_ready", 64'(issue_ready_o), 64'(1));
      chk("rst overflow", 64'(overflow_o), 64'(0));
      chk("rst wb_result", 64'(wb_result_o), 64'(0));
      chk("rst wb_trans_id", 64'(wb_trans_id_o), 64'(0));
    end else begin
      exp_v = !flush_i && (q.size() != 0 || fu_valid_i);
      chk("wb_valid", 64'(wb_valid_o), 64'(exp_v));
      if (exp_v) begin
        e = (q.size() != 0) ? q[0] : '{res: fu_result_i, id: fu_trans_id_i};
        chk("wb_result", 64'(wb_result_o), 64'(e.res));
        chk("wb_trans_id", 64'(wb_trans_id_o), 64'(e.id));
      end
      chk("occupancy", 64'(occupancy_o), 64'(q.size()));
      chk("issue_ready", 64'(issue_ready_o), 64'((q.size() + pipe_count()) < DEPTH));
      chk("overflow", 64'(overflow_o), 64'(model_ov));
    end
  endtask

  // Drive this cycle's inputs at posedge+1, then sample at the falling edge.
  task automatic settle();
    stage_t s = pipe[LAT-1];
    if (inj) begin
      fu_valid_i = 1'b1; fu_result_i = inj_ent.res; fu_trans_id_i = inj_ent.id;
    end else begin
      fu_valid_i    = s.vld;
      fu_result_i   = s.vld ? s.res : '0;
      fu_trans_id_i = s.vld ? s.id : '0;
    end
    issue_res     = fixed_en ? fixed_res : {$urandom, $urandom};
    issue_valid_i = want && issue_ready_o && !flush_i && rst_ni;
    @(negedge clk_i);
    compare_model();
    if (wb_valid_o && wb_ready_i) wb_log.push_back(wb_trans_id_o);
  endtask

  task automatic commit();
    bit was_empty;
    if (!rst_ni) begin
      model_reset();
    end else if (flush_i) begin
      q.delete();
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end else begin
      was_empty = (q.size() == 0);
      if (!was_empty && wb_ready_i) void'(q.pop_front());
      if (fu_valid_i && !(was_empty && wb_ready_i)) begin
        if (q.size() < DEPTH) q.push_back('{res: fu_result_i, id: fu_trans_id_i});
        else model_ov = 1'b1;
      end
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '{vld: issue_valid_i, res: issue_res, id: next_id};
      if (issue_valid_i) begin
        next_id++;
        issued++;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      settle();
      commit();
    end
  endtask

  task automatic inject_fill(input int n);
    inj = 1'b1;
    for (int i = 0; i < n; i++) begin
      inj_ent = '{res: {$urandom, $urandom}, id: TIDW'(i)};
      tick(1);
    end
    inj = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0; want = 1'b0; inj = 1'b0;
    fixed_en = 1'b0; fixed_res = '0; inj_ent = '0; issue_res = '0;
    fu_valid_i = 1'b0; fu_result_i = '0; fu_trans_id_i = '0; issue_valid_i = 1'b0;
    next_id = '0; issued = 0;
    model_reset();
    #2;
    tick(2);
    rst_ni = 1'b1;
    tick(1);

    // T1 bypass
    wb_ready_i = 1'b1; next_id = TIDW'(5); fixed_en = 1'b1; fixed_res = 64'h123; want = 1'b1;
    tick(1);
    want = 1'b0; fixed_en = 1'b0;
    tick(2);
    settle();
    chk("T1 wb_valid", 64'(wb_valid_o), 64'(1));
    chk("T1 wb_result", wb_result_o, 64'h123);
    chk("T1 wb_trans_id", 64'(wb_trans_id_o), 64'(5));
    chk("T1 occupancy", 64'(occupancy_o), 64'(0));
    commit();
    settle();
    chk("T1 occupancy after", 64'(occupancy_o), 64'(0));
    commit();

    // T2 backpressure and in-order drain
    wb_ready_i = 1'b0; next_id = '0; issued = 0; want = 1'b1;
    tick(8);
    want = 1'b0;
    chk("T2 issued", 64'(issued), 64'(4));
    settle();
    chk("T2 occupancy", 64'(occupancy_o), 64'(4));
    chk("T2 issue_ready", 64'(issue_ready_o), 64'(0));
    commit();
    wb_log.delete();
    wb_ready_i = 1'b1;
    tick(4);
    chk("T2 drain count", 64'(wb_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < wb_log.size(); i++) chk("T2 order", 64'(wb_log[i]), 64'(i));

    // T3 full with simultaneous push and pop
    wb_ready_i = 1'b0;
    inject_fill(4);
    wb_log.delete();
    wb_ready_i = 1'b1; inj = 1'b1; inj_ent = '{res: 64'hABCD, id: TIDW'(4)};
    tick(1);
    inj = 1'b0; wb_ready_i = 1'b0;
    settle();
    chk("T3 occupancy", 64'(occupancy_o), 64'(4));
    chk("T3 overflow", 64'(overflow_o), 64'(0));
    commit();
    wb_ready_i = 1'b1;
    tick(4);
    chk("T3 drain count", 64'(wb_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < wb_log.size(); i++) chk("T3 order", 64'(wb_log[i]), 64'(i));

    // T4 flush with 2 queued and 1 result arriving
    wb_ready_i = 1'b0; next_id = TIDW'(1); want = 1'b1;
    tick(3);
    want = 1'b0;
    tick(2);
    flush_i = 1'b1;
    settle();
    chk("T4 wb_valid in flush", 64'(wb_valid_o), 64'(0));
    chk("T4 occupancy before", 64'(occupancy_o), 64'(2));
    commit();
    flush_i = 1'b0;
    settle();
    chk("T4 occupancy after", 64'(occupancy_o), 64'(0));
    chk("T4 issue_ready after", 64'(issue_ready_o), 64'(1));
    commit();
    wb_log.delete();
    wb_ready_i = 1'b1;
    tick(6);
    chk("T4 no writeback", 64'(wb_log.size()), 64'(0));

    // T5 pointer wrap under random backpressure
    next_id = '0; issued = 0; wb_log.delete();
    for (int c = 0; c < 200 && wb_log.size() < 10; c++) begin
      want = (issued < 10);
      wb_ready_i = $urandom_range(0, 1) == 1;
      tick(1);
    end
    want = 1'b0;
    chk("T5 count", 64'(wb_log.size()), 64'(10));
    for (int i = 0; i < 10 && i < wb_log.size(); i++) chk("T5 order", 64'(wb_log[i]), 64'(i));

    // Random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      want       = $urandom_range(0, 3) != 0;
      wb_ready_i = $urandom_range(0, 2) != 0;
      flush_i    = $urandom_range(0, 31) == 0;
      tick(1);
    end
    flush_i = 1'b0; want = 1'b0; wb_ready_i = 1'b1;
    tick(8);

    // Overflow is sticky when a result hits a full queue with no pop
    wb_ready_i = 1'b0;
    inject_fill(5);
    settle();
    chk("T7 overflow", 64'(overflow_o), 64'(1));
    chk("T7 occupancy", 64'(occupancy_o), 64'(4));
    commit();
    wb_ready_i = 1'b1;
    tick(1);
    wb_ready_i = 1'b0;
    tick(1);

    // T6 async reset mid-cycle with 3 queued
    settle();
    chk("T6 occupancy before", 64'(occupancy_o), 64'(3));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("T6 wb_valid", 64'(wb_valid_o), 64'(0));
    chk("T6 occupancy", 64'(occupancy_o), 64'(0));
    chk("T6 issue_ready", 64'(issue_ready_o), 64'(1));
    chk("T6 overflow", 64'(overflow_o), 64'(0));
    model_reset();
    @(posedge clk_i);
    #1;
    tick(2);
    rst_ni = 1'b1;
    wb_log.delete();
    wb_ready_i = 1'b1;
    tick(3);
    chk("T6 no writeback", 64'(wb_log.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
